// File: rtl/otp_read_sequencer_if.sv
// Host-side request/response bus of the OTP read sequencer.
// master: the requester (drives req/addr/rready); slave: the sequencer.
interface otp_read_sequencer_if #(
  parameter int AW = 7,
  parameter int DW = 16
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ready;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          rerr;

  modport master (
    output req, addr, rready,
    input  ready, rvalid, rdata, rerr
  );

  modport slave (
    input  req, addr, rready,
    output ready, rvalid, rdata, rerr
  );
endinterface

// File: rtl/otp_read_sequencer.sv
// Read-side sequencer for the OTP macro: turns a word read request into a
// timed ce/address/strobe sequence, captures the macro word and returns it
// on a valid/ready response. Also gates the macro clock around each access.
//
// Optional build macro OTP_PARITY_CHK_EN: when defined, rerr flags an even
// parity mismatch over {otp_q, otp_p}; when undefined, rerr is always 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request, macro deselected, clock gate closed
// SETUP   | ce and address stable ahead of the strobe (T_SETUP cycles)
// STROBE  | read strobe high (T_STROBE cycles)
// CAPTURE | strobe low, macro output sampled into rdata/rerr (1 cycle)
// HOLD    | ce and address held after capture (T_HOLD cycles)
// DONE    | rvalid high, waiting for rready
module otp_read_sequencer #(
  parameter int AW       = 7,
  parameter int DW       = 16,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1
) (
  input  logic                 CP,
  input  logic                 RST,
  otp_read_sequencer_if.slave  bus,
  output logic [AW-1:0]        otp_a,
  output logic                 otp_ce,
  output logic                 otp_rd_strb,
  input  logic [DW-1:0]        otp_q,
  input  logic                 otp_p,
  output logic                 cg_en
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD  = 4'(T_SETUP - 1);
  localparam logic [3:0] STROBE_LD = 4'(T_STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(T_HOLD - 1);

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          accept;
  logic          cnt_tc;
  logic          par_bit;

  logic [AW-1:0] otp_a_d;
  logic          otp_ce_d, otp_rd_strb_d, cg_en_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  assign bus.ready  = (state == IDLE);
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rerr   = rerr_q;

  assign accept = bus.req & bus.ready;
  assign cnt_tc = (cnt == 4'd0);

`ifdef OTP_PARITY_CHK_EN
  assign par_bit = (^otp_q) ^ otp_p;
`else
  logic unused_otp_p;
  assign unused_otp_p = otp_p;
  assign par_bit      = 1'b0;
`endif

  // State and phase counter registers.
  always_ff @(posedge CP) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; the counter is reloaded whenever a timed phase is entered.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SETUP;
          cnt_nx   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_tc) begin
          state_nx = STROBE;
          cnt_nx   = STROBE_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_tc) begin
          state_nx = CAPTURE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        state_nx = HOLD;
        cnt_nx   = HOLD_LD;
      end
      HOLD: begin
        if (cnt_tc) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        if (rvalid_q && bus.rready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Output next-values are decoded from the next state so the registered
  // pins line up with the state they belong to; strobe can only be high
  // in a state where ce and cg_en are also high.
  always_comb begin
    otp_ce_d      = (state_nx == SETUP)  || (state_nx == STROBE) ||
                    (state_nx == CAPTURE) || (state_nx == HOLD);
    cg_en_d       = otp_ce_d;
    otp_rd_strb_d = (state_nx == STROBE);
    rvalid_d      = (state_nx == DONE);
    otp_a_d       = accept ? bus.addr : otp_a;
    rdata_d       = rdata_q;
    rerr_d        = rerr_q;
    if (state == CAPTURE) begin
      rdata_d = otp_q;
      rerr_d  = par_bit;
    end
  end

  // Registered macro pins and response outputs.
  always_ff @(posedge CP) begin
    if (RST) begin
      otp_a       <= '0;
      otp_ce      <= 1'b0;
      otp_rd_strb <= 1'b0;
      cg_en       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
    end else begin
      otp_a       <= otp_a_d;
      otp_ce      <= otp_ce_d;
      otp_rd_strb <= otp_rd_strb_d;
      cg_en       <= cg_en_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
    end
  end

endmodule

// File: doc/otp_read_sequencer.md
Name: otp_read_sequencer

Overview:
Read-side sequencer for the OTP macro. It accepts a word read request on a valid/ready handshake and drives the macro's address, chip-enable and read-strobe pins with programmable setup, strobe and hold timing. It captures the macro output and returns it on a valid/ready response handshake. It also drives the enable of the macro's clock gate (CKLNQD8) so the macro clock runs only during an access.

Parameters:
AW, 7, OTP word address width
DW, 16, OTP data word width
T_SETUP, 2, cycles of otp_ce/otp_a stable before strobe; legal range 1..15
T_STROBE, 4, cycles otp_rd_strb held high; legal range 1..15
T_HOLD, 1, cycles otp_ce/otp_a held after capture; legal range 1..15

Ports:
CP  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
req  input  1  read request valid
addr  input  AW  read word address, sampled on accept
ready  output  1  sequencer idle, can accept req
rvalid  output  1  read data valid
rready  input  1  consumer accepts rdata
rdata  output  DW  captured OTP word
rerr  output  1  parity error flag, qualified by rvalid
otp_a  output  AW  macro address
otp_ce  output  1  macro chip enable
otp_rd_strb  output  1  macro read strobe
otp_q  input  DW  macro read data
otp_p  input  1  macro parity bit
cg_en  output  1  enable to macro clock-gate cell

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered except ready (ready = state==IDLE).
- Reset values: state IDLE, ready=1, rvalid=0, rdata=0, rerr=0, otp_a=0, otp_ce=0, otp_rd_strb=0, cg_en=0, counter=0.
- FSM states: IDLE, SETUP, STROBE, CAPTURE, HOLD, DONE. A single down-counter of 4 bits is reloaded on each state entry.
- IDLE: if req&ready is sampled, latch addr into otp_a, set otp_ce=1 and cg_en=1, then go to SETUP with count T_SETUP-1.
- SETUP: ce=1, strb=0. When count==0, go to STROBE with count T_STROBE-1.
- STROBE: strb=1. When count==0, go to CAPTURE.
- CAPTURE (1 cycle): strb=0, ce=1. On exit, rdata<=otp_q and rerr<=parity result. Go to HOLD with count T_HOLD-1.
- HOLD: ce=1, otp_a stable. When count==0, go to DONE; ce drops and cg_en drops on entry to DONE; otp_a retained.
- DONE: rvalid=1, and rdata/rerr are held stable. When rvalid&rready is sampled, go to IDLE with rvalid=0. If rready is already high on entry, rvalid pulses for exactly one cycle.
- Latency from the accept edge to the first rvalid=1 cycle is T_SETUP+T_STROBE+1+T_HOLD cycles; the default is 8.
- req while not ready is ignored; addr changes after accept have no effect.
- Back-to-back: req high during the DONE handshake cycle is not accepted; it is accepted in the following IDLE cycle. Minimum spacing between accepts is latency+2.
- rdata changes only in CAPTURE and otherwise holds its last value.
- RST mid-access at any state forces reset values on the next edge. otp_rd_strb and otp_ce fall in the same cycle, and no rvalid follows.
- otp_rd_strb is never high unless otp_ce=1 and cg_en=1.

Optional Feature:
OTP_PARITY_CHK_EN
- Defined: in CAPTURE, rerr <= (^otp_q) ^ otp_p, i.e. even parity over DW+1 bits, so rerr=1 on mismatch. rdata is still returned.
- Undefined: otp_p is ignored and rerr is constant 0. Ports are identical in both builds.

Test Plan:
- Default parameters, otp_q=16'hA5C3, req=1 with addr=7'h15 -> ready falls next cycle; otp_a=7'h15; otp_ce high for 8 cycles; otp_rd_strb high exactly 4 cycles, starting 2 cycles after ce; rvalid=1 with rdata=16'hA5C3 8 cycles after accept.
- rready held low 5 cycles in DONE -> rvalid and rdata stay stable; one cycle after rready=1, ready=1 and rvalid=0.
- req held high continuously with rready=1 -> accepts occur every 10 cycles; the strobe count per access is always 4.
- RST asserted during the 2nd strobe cycle -> next edge gives otp_rd_strb=0, otp_ce=0, cg_en=0, ready=1; no rvalid follows.
- OTP_PARITY_CHK_EN defined, otp_q=16'h0001 with otp_p=0 -> rerr=1; with otp_p=1 -> rerr=0. With the macro undefined, rerr=0 in both cases.
- T_SETUP=1, T_STROBE=1, T_HOLD=1 -> latency 4 cycles; strobe is a single-cycle pulse; rdata is correct.
